// File: rtl/inv_sub_bytes_unit.sv
// ----------------------------------------------------------------------------
// inv_sub_bytes_unit
//
// Applies the AES InvSubBytes transform to one 128-bit state at a time, using
// LANES inverse S-box lookups per clock. A block is captured whole on accept.
// It is then converted in place, LANES bytes per cycle, starting at byte 0.
// The finished state is held until the consumer takes it.
//
// Handshake: an input block transfers on a rising edge where in_valid and
// in_ready are both 1, and in_ready is 1 only while the unit is idle. A result
// transfers on a rising edge where out_valid and out_ready are both 1. While
// out_valid is 1, state_out is stable. in_valid is ignored whenever in_ready
// is 0, so nothing is ever queued behind a block in flight.
//
// Parameters:
//   LANES       S-box lookups per cycle (1, 2 or 4); latency is 16/LANES edges
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   in_valid    state_in carries a block
//   in_ready    unit is idle and will accept a block
//   state_in    AES state, byte i = state_in[8i+7:8i]
//   out_valid   state_out holds a finished result
//   out_ready   consumer accepts the result
//   state_out   InvSubBytes result, same byte order; last result kept when idle
//   busy        conversion in progress
//   dbg_state_o current FSM state, for checkers
// ----------------------------------------------------------------------------
module inv_sub_bytes_unit #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("inv_sub_bytes_unit: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [4:0] STEP = 5'(LANES);

  // FIPS-197 inverse S-box. The packed range [0:255] places entry 0 in the
  // leftmost byte, so each 128-bit literal below reads as one table row.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  state_e       state_q, state_d;
  // Five bits so the count can land on 16 when the last bytes are converted;
  // reaching 16 exits BUSY instead of wrapping back to byte 0.
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   lane_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    lane_idx = '0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = state_in;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Every lane reads data_q, so lanes within a cycle are independent.
        for (int l = 0; l < LANES; l++) begin
          lane_idx = cnt_q[3:0] + 4'(l);
          data_d[{lane_idx, 3'b000} +: 8] = INV_SBOX[data_q[{lane_idx, 3'b000} +: 8]];
        end
        cnt_d = cnt_q + STEP;
        if (cnt_d == 5'd16) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q == S_BUSY);
  assign out_valid   = (state_q == S_DONE);
  assign state_out   = data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inv_sub_bytes_unit.sv
// ----------------------------------------------------------------------------
// tb_inv_sub_bytes_unit
//
// Three units (LANES = 1, 2, 4) share clk and rst; each has its own inputs.
// The reference S-boxes are derived from GF(2^8) inversion plus the AES affine
// map, not from a copied table. A per-cycle model tracks idle/converting/
// holding for each unit, and a scoreboard checks every delivered result.
// ----------------------------------------------------------------------------
module tb_inv_sub_bytes_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_a  [3];
  logic         out_ready_a [3];
  logic [127:0] state_in_a  [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         busy_a      [3];
  logic [127:0] state_out_a [3];
  logic [1:0]   dbg_a       [3];

  always #5 clk = ~clk;

  inv_sub_bytes_unit #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .state_in(state_in_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .state_out(state_out_a[0]), .busy(busy_a[0]), .dbg_state_o(dbg_a[0]));
  inv_sub_bytes_unit #(.LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .state_in(state_in_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .state_out(state_out_a[1]), .busy(busy_a[1]), .dbg_state_o(dbg_a[1]));
  inv_sub_bytes_unit #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .state_in(state_in_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
    .state_out(state_out_a[2]), .busy(busy_a[2]), .dbg_state_o(dbg_a[2]));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit model_on = 1'b0;

  task automatic check(input string name, input int k, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s unit%0d at cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // ---------------- reference S-boxes from field arithmetic ----------------
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);  // a^254 = a^-1, and 0 -> 0
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] inv_sub_model(input logic [127:0] blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[blk[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] fwd_sub_model(input logic [127:0] blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_tab[blk[8*i +: 8]];
    return r;
  endfunction

  function automatic int lat_of(input int k);
    return 16 / (1 << k);
  endfunction

  // ---------------- per-unit behavioural model ----------------
  bit           m_busy  [3];
  bit           m_done  [3];
  int           m_left  [3];
  logic [127:0] m_cap   [3];
  logic [127:0] m_out   [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0; m_done[k] = 1'b0; m_left[k] = 0; m_out[k] = '0;
      end else if (!m_busy[k] && !m_done[k]) begin
        if (in_valid_a[k]) begin
          m_cap[k] = state_in_a[k]; m_left[k] = lat_of(k); m_busy[k] = 1'b1;
        end
      end else if (m_busy[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_busy[k] = 1'b0; m_done[k] = 1'b1; m_out[k] = inv_sub_model(m_cap[k]);
        end
      end else if (out_ready_a[k]) begin
        m_done[k] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard + per-cycle compare ----------------
  logic [127:0] exp_q[$];
  logic [127:0] nxt_exp_a [3];

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        check("in_ready", k, 128'(in_ready_a[k]), 128'(!m_busy[k] && !m_done[k]));
        check("busy", k, 128'(busy_a[k]), 128'(m_busy[k]));
        check("out_valid", k, 128'(out_valid_a[k]), 128'(m_done[k]));
        if (!m_busy[k]) check("state_out", k, state_out_a[k], m_out[k]);
        if (rst) begin
          exp_q.delete();
        end else begin
          if (out_valid_a[k] && out_ready_a[k]) begin
            if (exp_q.size() == 0) check("sb_unexpected", k, 128'd1, 128'd0);
            else check("sb_result", k, state_out_a[k], exp_q.pop_front());
          end
          if (in_valid_a[k] && in_ready_a[k]) exp_q.push_back(nxt_exp_a[k]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_only(input int k, input logic [127:0] blk, input logic [127:0] exp);
    int g;
    g = 0;
    while (!in_ready_a[k] && g < 64) begin tick(); g++; end
    check("accept_timeout", k, 128'(in_ready_a[k]), 128'd1);
    in_valid_a[k] = 1'b1; state_in_a[k] = blk; nxt_exp_a[k] = exp;
    tick();
    in_valid_a[k] = 1'b0;
  endtask

  task automatic wait_result(input int k, output int lat);
    lat = 0;
    while (!out_valid_a[k] && lat < 64) begin tick(); lat++; end
    check("result_timeout", k, 128'(out_valid_a[k]), 128'd1);
  endtask

  task automatic send(input int k, input logic [127:0] blk, input logic [127:0] exp);
    int lat;
    send_only(k, blk, exp);
    wait_result(k, lat);
    check("latency", k, 128'(lat), 128'(lat_of(k)));
    check("direct_result", k, state_out_a[k], exp);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] BLK_D4  = {16{8'hd4}};
  localparam logic [127:0] RES_D4  = {16{8'h19}};
  localparam logic [127:0] BLK_63  = {{15{8'h63}}, 8'h7c};
  localparam logic [127:0] RES_63  = 128'h1;
  localparam logic [127:0] BLK_MIX = {8{16'h107c}};
  localparam logic [127:0] RES_MIX = {8{16'h7c01}};

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat, sent, last_acc, g;
    logic [127:0] orig, prev;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b1; state_in_a[k] = '0; nxt_exp_a[k] = '0;
      m_busy[k] = 1'b0; m_done[k] = 1'b0; m_left[k] = 0; m_out[k] = '0; m_cap[k] = '0;
    end
    for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_calc(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    // Pin the reference tables with known FIPS-197 entries.
    check("pin_inv_d4", 0, 128'(inv_tab[8'hd4]), 128'h19);
    check("pin_inv_10", 0, 128'(inv_tab[8'h10]), 128'h7c);
    check("pin_inv_63", 0, 128'(inv_tab[8'h63]), 128'h00);
    check("pin_inv_7c", 0, 128'(inv_tab[8'h7c]), 128'h01);
    check("pin_fwd_53", 0, 128'(fwd_tab[8'h53]), 128'hed);

    tick();
    model_on = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("reset_in_ready", k, 128'(in_ready_a[k]), 128'd1);
      check("reset_state_out", k, state_out_a[k], 128'h0);
    end
    rst = 1'b0;

    // First edge after reset release accepts.
    send(0, BLK_D4, RES_D4);
    send(0, BLK_63, RES_63);
    send(1, BLK_63, RES_63);
    send(2, BLK_63, RES_63);
    send(2, 128'h0, {16{8'h52}});
    send(1, {16{8'h10}}, {16{8'h7c}});

    // Consumer stalls in DONE with a new block already offered.
    out_ready_a[0] = 1'b0;
    send(0, BLK_D4, RES_D4);
    in_valid_a[0] = 1'b1; state_in_a[0] = BLK_63; nxt_exp_a[0] = RES_63;
    repeat (5) begin
      tick();
      check("stall_out_valid", 0, 128'(out_valid_a[0]), 128'd1);
      check("stall_in_ready", 0, 128'(in_ready_a[0]), 128'd0);
      check("stall_state_out", 0, state_out_a[0], RES_D4);
    end
    out_ready_a[0] = 1'b1;
    tick();
    check("release_idle", 0, 128'(in_ready_a[0]), 128'd1);
    check("idle_keeps_result", 0, state_out_a[0], RES_D4);
    tick();
    check("next_accept_busy", 0, 128'(busy_a[0]), 128'd1);
    in_valid_a[0] = 1'b0;
    wait_result(0, lat);
    check("after_stall_result", 0, state_out_a[0], RES_63);
    tick();

    // Reset on the 7th BUSY edge aborts the block.
    send_only(0, BLK_D4, RES_D4);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 0, 128'(in_ready_a[0]), 128'd1);
    check("abort_out_valid", 0, 128'(out_valid_a[0]), 128'd0);
    check("abort_state_out", 0, state_out_a[0], 128'h0);
    repeat (24) begin
      tick();
      check("abort_no_pulse", 0, 128'(out_valid_a[0]), 128'd0);
    end

    // state_in wiggles during BUSY; only the captured value counts.
    for (int k = 1; k < 3; k++) begin
      send_only(k, BLK_MIX, RES_MIX);
      g = 0;
      while (!out_valid_a[k] && g < 64) begin
        state_in_a[k] = {$urandom, $urandom, $urandom, $urandom};
        tick(); g++;
      end
      check("wiggle_latency", k, 128'(g), 128'(lat_of(k)));
      check("wiggle_result", k, state_out_a[k], RES_MIX);
      tick();
    end

    // Round trip: forward-substituted random blocks, back to back.
    sent = 0; last_acc = 0; g = 0;
    in_valid_a[0] = 1'b1;
    while (sent < 1000 && g < 40000) begin
      if (in_ready_a[0]) begin
        orig = {$urandom, $urandom, $urandom, $urandom};
        state_in_a[0] = fwd_sub_model(orig);
        nxt_exp_a[0]  = orig;
        if (sent > 0) check("accept_interval", 0, 128'(cyc - last_acc), 128'(lat_of(0) + 2));
        last_acc = cyc;
        sent++;
      end
      tick(); g++;
    end
    in_valid_a[0] = 1'b0;
    check("roundtrip_sent", 0, 128'(sent), 128'd1000);
    wait_result(0, lat);
    prev = state_out_a[0];
    tick();
    tick();
    check("roundtrip_last_kept", 0, state_out_a[0], prev);
    check("sb_drained", 0, 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
